dmem_stall_responder: RTL and testbench



---
 rtl/dmem_stall_responder.sv | 186 ++++++++++++++++++
 tb/tb_dmem_stall_responder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_stall_responder.sv
// dmem_stall_responder
//   Memory-side responder for the CPU data-memory load/store interface.
//   It is a word-organised store that takes one request at a time. Each
//   request is answered LATENCY cycles after acceptance. The pipeline is
//   frozen through stall_o until the answer is delivered.
//
//   State | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no transaction; a request on req_i is accepted here
//   WAIT  | transaction in flight; cnt counts down; inputs ignored
//   RESP  | ack_o pulse; a store is committed on the edge leaving RESP
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words in the storage array
//   LATENCY      cycles from acceptance to ack_o (1..15)
//   ADDR_W       byte-address width
//
// Ports:
//   clk_i    in   clock, rising edge
//   rst_i    in   asynchronous, active-high reset
//   req_i    in   request valid, held by the CPU while stall_o=1
//   we_i     in   1 = store, 0 = load
//   addr_i   in   byte address; word index = addr_i[ADDR_W-1:2]
//   wdata_i  in   store data
//   rdata_o  out  load data, valid with ack_o and held until the next ack
//   ack_o    out  one-cycle completion pulse
//   stall_o  out  pipeline freeze
//   err_o    out  misaligned or out-of-range access, qualified by ack_o
//
// Optional feature: define DMEM_LASTWORD_BUF_EN to add a one-entry
//   last-word buffer. A load that hits the buffer completes with latency 1.

module dmem_stall_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 4,
  parameter int ADDR_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              ack_o,
  output logic              stall_o,
  output logic              err_o
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_W-2:0] DEPTH_CMP = (ADDR_W-1)'(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > 15) begin : g_latency_range
    $error("dmem_stall_responder: LATENCY must be within 1..15");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [3:0]        cnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       mem [DEPTH_WORDS];

  logic              accept;
  logic              cur_we;
  logic [ADDR_W-1:0] cur_addr;
  logic              cur_err;
  logic              err_q;
  logic [IDX_W-1:0]  cur_idx;
  logic [IDX_W-1:0]  idx_q;
  logic              buf_hit;
  logic [31:0]       rd_src;

  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    return (a[1:0] != 2'b00) || ({1'b0, a[ADDR_W-1:2]} >= DEPTH_CMP);
  endfunction

  assign accept = (state == IDLE) && req_i;

  // In IDLE the request is being latched on the same edge that may enter
  // RESP (latency 1 or buffer hit), so the live inputs are used there.
  assign cur_we   = (state == IDLE) ? we_i   : we_q;
  assign cur_addr = (state == IDLE) ? addr_i : addr_q;
  assign cur_err  = addr_bad(cur_addr);
  assign cur_idx  = cur_addr[IDX_W+1:2];
  assign idx_q    = addr_q[IDX_W+1:2];
  assign err_q    = addr_bad(addr_q);

`ifdef DMEM_LASTWORD_BUF_EN
  logic             buf_valid;
  logic [IDX_W-1:0] buf_idx;
  logic [31:0]      buf_data;

  assign buf_hit = accept && !we_i && !cur_err && buf_valid && (buf_idx == cur_idx);
  assign rd_src  = buf_hit ? buf_data : mem[cur_idx];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      buf_valid <= 1'b0;
      buf_idx   <= '0;
      buf_data  <= '0;
    end else if ((state_nxt == RESP) && !cur_we && !cur_err) begin
      buf_valid <= 1'b1;
      buf_idx   <= cur_idx;
      buf_data  <= rd_src;
    end else if ((state == RESP) && we_q && !err_q) begin
      buf_valid <= 1'b1;
      buf_idx   <= idx_q;
      buf_data  <= wdata_q;
    end
  end
`else
  assign buf_hit = 1'b0;
  assign rd_src  = mem[cur_idx];
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_i) begin
          state_nxt = ((LATENCY == 1) || buf_hit) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd1) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ack_o   = (state == RESP);
  assign err_o   = (state == RESP) && err_q;
  assign stall_o = accept || (state == WAIT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_o <= '0;
    end else begin
      if (accept) begin
        we_q    <= we_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        cnt     <= CNT_INIT;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      // Stores and errored accesses answer with zero data.
      if (state_nxt == RESP) begin
        rdata_o <= (!cur_we && !cur_err) ? rd_src : 32'h0;
      end
    end
  end

  // The array is deliberately not reset; state is IDLE during reset so a
  // dropped transaction never reaches the write below.
  always_ff @(posedge clk_i) begin
    if ((state == RESP) && we_q && !err_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_dmem_stall_responder.sv
module tb_dmem_stall_responder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        ack_o;
  logic        stall_o;
  logic        err_o;

  int passed = 0;
  int total  = 0;

`ifdef DMEM_LASTWORD_BUF_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = 4;
`endif

  dmem_stall_responder #(
    .DEPTH_WORDS(256),
    .LATENCY    (4),
    .ADDR_W     (32)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .req_i  (req_i),
    .we_i   (we_i),
    .addr_i (addr_i),
    .wdata_i(wdata_i),
    .rdata_o(rdata_o),
    .ack_o  (ack_o),
    .stall_o(stall_o),
    .err_o  (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // Issue one request and check every cycle up to one cycle past the ack.
  task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input int lat,
                      input logic [31:0] exp_rd, input logic exp_err);
    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata;
    #1;
    chk({tag, " stall@acc"}, 32'(stall_o), 32'd1);
    chk({tag, " ack@acc"}, 32'(ack_o), 32'd0);
    for (int c = 1; c < lat; c++) begin
      cyc();
      chk({tag, " stall@wait"}, 32'(stall_o), 32'd1);
      chk({tag, " ack@wait"}, 32'(ack_o), 32'd0);
    end
    cyc();
    chk({tag, " ack"}, 32'(ack_o), 32'd1);
    chk({tag, " stall@ack"}, 32'(stall_o), 32'd0);
    chk({tag, " err"}, 32'(err_o), 32'(exp_err));
    chk({tag, " rdata"}, rdata_o, exp_rd);
    req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
    cyc();
    chk({tag, " ack@after"}, 32'(ack_o), 32'd0);
    chk({tag, " err@after"}, 32'(err_o), 32'd0);
    chk({tag, " rdata hold"}, rdata_o, exp_rd);
  endtask

  initial begin
    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
    repeat (3) cyc();
    chk("reset ack", 32'(ack_o), 32'd0);
    chk("reset stall", 32'(stall_o), 32'd0);
    chk("reset err", 32'(err_o), 32'd0);
    chk("reset rdata", rdata_o, 32'h0);
    rst_i = 1'b0;
    cyc();

    // 1: reset in the middle of WAIT drops a store
    xact("t1 st", 1'b1, 32'h0C, 32'h1111_1111, 4, 32'h0, 1'b0);
    xact("t1 ld", 1'b0, 32'h0C, 32'h0, HIT_LAT, 32'h1111_1111, 1'b0);
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h0C; wdata_i = 32'h2222_2222;
    cyc();
    cyc();
    chk("t1 stall mid-wait", 32'(stall_o), 32'd1);
    #2 rst_i = 1'b1;
    req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
    #1;
    chk("t1 rst ack", 32'(ack_o), 32'd0);
    chk("t1 rst stall", 32'(stall_o), 32'd0);
    chk("t1 rst rdata", rdata_o, 32'h0);
    cyc();
    rst_i = 1'b0;
    for (int c = 0; c < 6; c++) begin
      cyc();
      chk("t1 post ack", 32'(ack_o), 32'd0);
      chk("t1 post stall", 32'(stall_o), 32'd0);
    end
    chk("t1 post rdata", rdata_o, 32'h0);
    xact("t1 ld after", 1'b0, 32'h0C, 32'h0, 4, 32'h1111_1111, 1'b0);

    // 2: store then load at the same address
    xact("t2 st", 1'b1, 32'h0C, 32'hDEAD_BEEF, 4, 32'h0, 1'b0);
    xact("t2 ld", 1'b0, 32'h0C, 32'h0, HIT_LAT, 32'hDEAD_BEEF, 1'b0);

    // 3: error accesses leave the array untouched
    xact("t3 ld misal", 1'b0, 32'h0E, 32'h0, 4, 32'h0, 1'b1);
    xact("t3 st 0", 1'b1, 32'h00, 32'hA5A5_A5A5, 4, 32'h0, 1'b0);
    xact("t3 st oor", 1'b1, 32'h400, 32'h0000_0BAD, 4, 32'h0, 1'b1);
    xact("t3 st misal", 1'b1, 32'h0D, 32'h1234_5678, 4, 32'h0, 1'b1);
    xact("t3 ld 0", 1'b0, 32'h00, 32'h0, HIT_LAT, 32'hA5A5_A5A5, 1'b0);
    xact("t3 ld c", 1'b0, 32'h0C, 32'h0, 4, 32'hDEAD_BEEF, 1'b0);

    // 4: back-to-back loads with req_i held high
    xact("t4 st 4", 1'b1, 32'h04, 32'h0000_0044, 4, 32'h0, 1'b0);
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h00;
    #1;
    chk("t4 stall acc0", 32'(stall_o), 32'd1);
    for (int c = 1; c < 4; c++) begin
      cyc();
      chk("t4 stall wait0", 32'(stall_o), 32'd1);
      chk("t4 ack wait0", 32'(ack_o), 32'd0);
    end
    cyc();
    chk("t4 ack0", 32'(ack_o), 32'd1);
    chk("t4 rdata0", rdata_o, 32'hA5A5_A5A5);
    addr_i = 32'h04;
    #1;
    chk("t4 stall ack0", 32'(stall_o), 32'd0);
    cyc();
    chk("t4 ack idle", 32'(ack_o), 32'd0);
    chk("t4 stall acc1", 32'(stall_o), 32'd1);
    for (int c = 1; c < 4; c++) begin
      cyc();
      chk("t4 stall wait1", 32'(stall_o), 32'd1);
      chk("t4 ack wait1", 32'(ack_o), 32'd0);
    end
    cyc();
    chk("t4 ack1", 32'(ack_o), 32'd1);
    chk("t4 stall ack1", 32'(stall_o), 32'd0);
    chk("t4 rdata1", rdata_o, 32'h0000_0044);
    req_i = 1'b0; addr_i = '0;
    cyc();
    chk("t4 ack after", 32'(ack_o), 32'd0);

    // 5: req_i dropped during WAIT does not cancel the store
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h10; wdata_i = 32'h5;
    #1;
    chk("t5 stall acc", 32'(stall_o), 32'd1);
    cyc();
    req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
    #1;
    chk("t5 stall wait", 32'(stall_o), 32'd1);
    for (int c = 2; c < 4; c++) begin
      cyc();
      chk("t5 stall wait", 32'(stall_o), 32'd1);
      chk("t5 ack wait", 32'(ack_o), 32'd0);
    end
    cyc();
    chk("t5 ack", 32'(ack_o), 32'd1);
    chk("t5 err", 32'(err_o), 32'd0);
    chk("t5 rdata", rdata_o, 32'h0);
    cyc();
    chk("t5 ack after", 32'(ack_o), 32'd0);
    xact("t5 ld", 1'b0, 32'h10, 32'h0, HIT_LAT, 32'h5, 1'b0);

`ifdef DMEM_LASTWORD_BUF_EN
    // 6: last-word buffer hit and miss
    xact("t6 st 24", 1'b1, 32'h24, 32'h99, 4, 32'h0, 1'b0);
    xact("t6 st 20", 1'b1, 32'h20, 32'h77, 4, 32'h0, 1'b0);
    xact("t6 ld 20", 1'b0, 32'h20, 32'h0, 1, 32'h77, 1'b0);
    xact("t6 ld 24", 1'b0, 32'h24, 32'h0, 4, 32'h99, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
